argmax_out_15_16: RTL and testbench



---
 rtl/nn_pkg.sv | 17 +
 rtl/argmax_cmp.sv | 27 ++
 rtl/argmax_out_15_16.sv | 101 ++++++++++
 tb/tb_argmax_out_15_16.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the classifier datapath stages.
package nn_pkg;

  localparam int WIDTH = 16;

  typedef logic signed [WIDTH-1:0] sample_t;

  typedef enum logic {ACCUM, DONE} am_state_t;

  // Index widths must never collapse to zero bits, even for a single-entry vector.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare-and-select between the running winner and a new candidate.
// A strict greater-than keeps the earlier index on ties; 'first' forces the candidate
// to win so nothing from a previous vector can leak into a new one.
module argmax_cmp #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 4
) (
  input  logic signed [WIDTH-1:0] cur_val,
  input  logic        [IDXW-1:0]  cur_idx,
  input  logic signed [WIDTH-1:0] new_val,
  input  logic        [IDXW-1:0]  new_idx,
  input  logic                    first,
  output logic signed [WIDTH-1:0] win_val,
  output logic        [IDXW-1:0]  win_idx
);
  import nn_pkg::*;

  logic take_new;

  // Pick the candidate when starting a vector or when it is strictly larger.
  always_comb begin
    take_new = first || (new_val > cur_val);
    win_val  = take_new ? new_val : cur_val;
    win_idx  = take_new ? new_idx : cur_idx;
  end

endmodule

// File: rtl/argmax_out_15_16.sv
// Final classification stage: groups L accepted samples into one vector and reports
// the index and value of its signed maximum over a valid/ready result port.
// Input readiness and result validity are decoded purely from the state register,
// so neither handshake has a combinational path back to the other side.
module argmax_out_15_16 #(
  parameter  int L     = 15,
  parameter  int WIDTH = 16,
  localparam int IDXW  = nn_pkg::clog2_min1(L)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_x,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  output logic        [IDXW-1:0]  m_index_y,
  output logic signed [WIDTH-1:0] m_max_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y
);
  import nn_pkg::*;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(L - 1);

  am_state_t state;
  am_state_t state_next;

  logic        [IDXW-1:0]  count;
  logic signed [WIDTH-1:0] best_val;
  logic        [IDXW-1:0]  best_idx;
  logic signed [WIDTH-1:0] win_val;
  logic        [IDXW-1:0]  win_idx;

  logic in_hs;
  logic out_hs;
  logic first_sample;
  logic last_sample;

  assign s_ready_x    = (state == ACCUM);
  assign m_valid_y    = (state == DONE);
  assign in_hs        = s_valid_x && s_ready_x;
  assign out_hs       = m_valid_y && m_ready_y;
  assign first_sample = (count == '0);
  assign last_sample  = (count == LAST_IDX);

  argmax_cmp #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_cmp (
    .cur_val (best_val),
    .cur_idx (best_idx),
    .new_val (s_data_in_x),
    .new_idx (count),
    .first   (first_sample),
    .win_val (win_val),
    .win_idx (win_idx)
  );

  // State register; reset drops any pending result at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next state: finish a vector on its last sample, return once the result is taken.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (in_hs && last_sample) state_next = DONE;
      DONE:    if (out_hs)               state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Running winner and sample position within the current vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else if (in_hs) begin
      best_val <= win_val;
      best_idx <= win_idx;
      count    <= last_sample ? '0 : count + IDXW'(1);
    end
  end

  // Capture the final winner, including the closing sample, and hold it while DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_max_y   <= '0;
      m_index_y <= '0;
    end else if (in_hs && last_sample) begin
      m_max_y   <= win_val;
      m_index_y <= win_idx;
    end
  end

endmodule

// File: tb/tb_argmax_out_15_16.sv
// Directed and randomised checks of the argmax classification stage.
module tb_argmax_out_15_16;
  import nn_pkg::*;

  localparam int L    = 15;
  localparam int IDXW = 4;

  logic            clk = 1'b0;
  logic            reset;
  sample_t         s_data_in_x;
  logic            s_valid_x;
  logic            s_ready_x;
  logic [IDXW-1:0] m_index_y;
  sample_t         m_max_y;
  logic            m_valid_y;
  logic            m_ready_y;

  int checks   = 0;
  int failures = 0;

  sample_t vec [L];

  argmax_out_15_16 #(
    .L     (L),
    .WIDTH (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data_in_x (s_data_in_x),
    .s_valid_x   (s_valid_x),
    .s_ready_x   (s_ready_x),
    .m_index_y   (m_index_y),
    .m_max_y     (m_max_y),
    .m_valid_y   (m_valid_y),
    .m_ready_y   (m_ready_y)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside a bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input sample_t value, input int gapPct);
    int waitCycles;
    waitCycles = 0;
    while (($urandom_range(0, 99) < gapPct) && (waitCycles < 3)) begin
      s_valid_x = 1'b0;
      tick();
      waitCycles++;
    end
    s_valid_x   = 1'b1;
    s_data_in_x = value;
    waitCycles  = 0;
    while (!s_ready_x && (waitCycles < 100)) begin
      tick();
      waitCycles++;
    end
    if (!s_ready_x) checkOutput("input_stall_timeout", 0, 1);
    tick();
    s_valid_x = 1'b0;
  endtask

  task automatic sendVector(input int gapPct);
    for (int i = 0; i < L; i++) applyStimulus(vec[i], gapPct);
  endtask

  task automatic awaitResult(input int expIdx, input int expMax, input int readyPct,
                             input string tag);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && (n < 200)) begin
      m_ready_y = ($urandom_range(0, 99) < readyPct);
      if (m_valid_y && m_ready_y) begin
        checkOutput({tag, "_idx"}, m_index_y, expIdx);
        checkOutput({tag, "_max"}, m_max_y, expMax);
        tick();
        done = 1'b1;
      end else begin
        tick();
        n++;
      end
    end
    m_ready_y = 1'b0;
    if (!done) checkOutput({tag, "_timeout"}, 0, 1);
    else checkOutput({tag, "_drop"}, m_valid_y, 0);
  endtask

  task automatic computeModel(output int idx, output int mx);
    idx = 0;
    mx  = vec[0];
    for (int i = 1; i < L; i++) begin
      if (vec[i] > mx) begin
        mx  = vec[i];
        idx = i;
      end
    end
  endtask

  initial begin
    int expIdx;
    int expMax;

    reset       = 1'b0;
    s_valid_x   = 1'b0;
    s_data_in_x = '0;
    m_ready_y   = 1'b0;
    #12;
    checkOutput("rst_valid", m_valid_y, 0);
    checkOutput("rst_index", m_index_y, 0);
    checkOutput("rst_max",   m_max_y,   0);
    checkOutput("rst_ready", s_ready_x, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Ascending vector with the result port always ready: one-cycle result pulse.
    m_ready_y = 1'b1;
    for (int i = 0; i < L - 1; i++) applyStimulus(sample_t'(i), 0);
    checkOutput("asc_valid_early", m_valid_y, 0);
    applyStimulus(sample_t'(14), 0);
    checkOutput("asc_valid", m_valid_y, 1);
    checkOutput("asc_idx",   m_index_y, 14);
    checkOutput("asc_max",   m_max_y,   14);
    checkOutput("asc_ready_low", s_ready_x, 0);
    tick();
    checkOutput("asc_valid_drop", m_valid_y, 0);
    checkOutput("asc_ready_back", s_ready_x, 1);
    m_ready_y = 1'b0;

    // Tie resolves to the first occurrence.
    for (int i = 0; i < L; i++) vec[i] = '0;
    vec[0] = 5; vec[1] = 9; vec[2] = 3; vec[3] = 9; vec[4] = 1;
    sendVector(0);
    awaitResult(1, 9, 100, "tie");

    // All-negative vector must report its true negative maximum.
    for (int i = 0; i < L; i++) vec[i] = sample_t'(-86 - i);
    sendVector(0);
    awaitResult(0, -86, 100, "neg");

    // Result held stable under back-pressure while the next sample waits.
    for (int i = 0; i < L; i++) vec[i] = sample_t'(i * 10 - 50);
    sendVector(0);
    checkOutput("bp_valid", m_valid_y, 1);
    for (int i = 0; i < L; i++) vec[i] = sample_t'(i);
    vec[6] = 7000;
    s_valid_x   = 1'b1;
    s_data_in_x = vec[0];
    for (int c = 0; c < 20; c++) begin
      tick();
      checkOutput("bp_hold_valid", m_valid_y, 1);
      checkOutput("bp_hold_idx",   m_index_y, 14);
      checkOutput("bp_hold_max",   m_max_y,   90);
      checkOutput("bp_hold_ready", s_ready_x, 0);
    end
    m_ready_y = 1'b1;
    tick();
    m_ready_y = 1'b0;
    checkOutput("bp_release", m_valid_y, 0);
    sendVector(0);
    awaitResult(6, 7000, 100, "bp_second");

    // Reset while a result is pending drops it without a clock edge.
    for (int i = 0; i < L; i++) vec[i] = sample_t'(3 * i);
    sendVector(0);
    checkOutput("done_rst_pre", m_valid_y, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("done_rst_valid", m_valid_y, 0);
    checkOutput("done_rst_ready", s_ready_x, 1);
    tick();
    reset = 1'b1;
    tick();

    // Reset part-way through vector A; only vector B may produce a result.
    for (int i = 0; i < L; i++) vec[i] = sample_t'(i);
    vec[3] = 500;
    for (int i = 0; i < 8; i++) applyStimulus(vec[i], 0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", m_valid_y, 0);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < L; i++) vec[i] = sample_t'(i - 20);
    vec[11] = 42;
    sendVector(0);
    awaitResult(11, 42, 100, "mid_rst_b");
    tick();
    tick();
    checkOutput("mid_rst_no_extra", m_valid_y, 0);

    // Random vectors with input gaps and random result acceptance.
    for (int v = 0; v < 200; v++) begin
      for (int i = 0; i < L; i++) begin
        if (v % 2 == 1) vec[i] = sample_t'(int'($urandom_range(0, 7)) - 4);
        else vec[i] = sample_t'($urandom);
      end
      computeModel(expIdx, expMax);
      sendVector(50);
      awaitResult(expIdx, expMax, 50, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
